fifo_wr_arbiter: RTL and testbench
==================================

// Module: fifo_wr_arbiter
// PURPOSE
//  Round-robin write-side arbiter sharing one async FIFO write port among NREQ requesters.
//  Sits in the write clock domain and drives the FIFO's wdata/winc from the FIFO's full flag.
//  Grants bursts of up to MAXBURST words per requester, then rotates priority.
// PARAMETERS
//  DSIZE     8  data word width; equals the FIFO DSIZE
//  NREQ      4  number of requesters; must be >= 1
//  MAXBURST  4  max words per grant before forced rotation; must be >= 1
// PORTS
//  wclk      in   1           write clock; the only clock
//  w_rst     in   1           reset, asynchronous, active-low
//  req       in   NREQ        req[i]=1: requester i has a word on its data slice
//  req_data  in   NREQ*DSIZE  requester i data at [i*DSIZE +: DSIZE]
//  full      in   1           FIFO full flag, write domain
//  gnt       out  NREQ        registered one-hot grant; all-zero when idle
//  ack       out  NREQ        word of requester i accepted this cycle: gnt[i]&req[i]&~full
//  wdata     out  DSIZE       FIFO write data: req_data slice of granted requester, else 0
//  winc      out  1           FIFO write enable: |ack
//  busy      out  1           1 while in GRANT state
// BEHAVIOUR
//  Reset (w_rst=0, async): state=IDLE, gnt=0, ptr=0, bcnt=0.
//   Combinational outputs follow immediately: winc=0, ack=0, wdata=0, busy=0.
//  State widths:
//   ptr: max(1,$clog2(NREQ)) bits; wraps NREQ-1 -> 0.
//   bcnt: $clog2(MAXBURST+1) bits.
//  Round-robin search: first set req bit scanning ptr, ptr+1, ... modulo NREQ.
//  IDLE:
//   - Any req set -> gnt loads one-hot of the search winner on the next edge; state=GRANT; bcnt=0.
//   - Arbitration latency is 1 cycle from req to gnt.
//   - No req -> stay IDLE.
//  GRANT, granted index g:
//   - Transfer cycle: req[g]&~full -> winc=1, ack[g]=1, wdata=slice g, bcnt+1.
//   - full=1 -> no transfer; gnt held; bcnt frozen. full never releases the grant.
//   - Release: req[g]=0 this cycle (no transfer), or a transfer with bcnt==MAXBURST-1.
//   - On release: ptr=(g+1) mod NREQ; re-search req with the new ptr in the same cycle.
//     - Winner found (g included, lowest priority) -> gnt=winner next edge, bcnt=0, stay GRANT.
//       No bubble.
//     - No winner -> gnt=0, state=IDLE.
//   - Word accepted on a release cycle counts; the new grant takes effect the following cycle.
//  Requester rules:
//   - Hold req and data stable until ack.
//   - May drop req without ack; the word is withdrawn, nothing is written.
//  NREQ=1: ptr stays 0; gnt stays 1 across releases while req held; bcnt restarts.
//  Never more than one ack or gnt bit set. winc never high while full=1.
// TESTING
//  1 Reset: w_rst=0 with req=4'hF, full=0 -> gnt=0, winc=0, wdata=0, busy=0.
//    Release reset, req=0 -> remains idle.
//  2 NREQ=4, MAXBURST=4, req=4'b0100, data2=8'hA5, full=0:
//    gnt=4'b0100 one cycle after req; winc high 4 cycles with wdata=A5.
//    Then gnt stays 0100 with bcnt reset (sole requester); winc continuous.
//  3 req=4'hF held, full=0:
//    grants rotate 0001->0010->0100->1000->0001, 4 words each; winc stays 1 with no gaps.
//  4 Mid-burst of requester 1 (2 words done), full=1 for 5 cycles:
//    winc=0, ack=0, gnt=0010 held; after full=0, exactly 2 more words, then rotate.
//  5 Requester 1 granted drops req after 2 words, req[3]=1:
//    one cycle with winc=0, then gnt=4'b1000 next edge, ptr=2 at the switch.
//  6 Assert w_rst mid-burst:
//    gnt/winc/ack drop to 0 without a clock edge.
//    After release with req=4'b1001, first gnt=4'b0001 (ptr back to 0).

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for a shared async FIFO write port
module fifo_wr_arbiter #(
  parameter int DSIZE    = 8,
  parameter int NREQ     = 4,
  parameter int MAXBURST = 4
) (
  input  logic                  wclk,
  input  logic                  w_rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  input  logic                  full,
  output logic [NREQ-1:0]       gnt,
  output logic [NREQ-1:0]       ack,
  output logic [DSIZE-1:0]      wdata,
  output logic                  winc,
  output logic                  busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = (MAXBURST > 0) ? $clog2(MAXBURST + 1) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]     ptr_q, ptr_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;

  logic [PW-1:0]     gidx;
  logic [PW-1:0]     ptr_nxt;
  logic              req_g;
  logic              xfer;
  logic              release_g;
  logic [NREQ-1:0]   pick_idle;
  logic [NREQ-1:0]   pick_rel;

  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [PW-1:0] p);
    logic [NREQ-1:0] hi;
    logic [NREQ-1:0] oh;
    logic [NREQ-1:0] src;
    hi = '0;
    oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      hi[i] = r[i] && (i >= int'(p));
    end
    src = (|hi) ? hi : r;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (src[i]) begin
        oh    = '0;
        oh[i] = 1'b1;
      end
    end
    return oh;
  endfunction

  always_comb begin
    gidx  = '0;
    wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) begin
        gidx = PW'(i);
      end
      wdata = wdata | ({DSIZE{gnt_q[i]}} & req_data[i*DSIZE +: DSIZE]);
    end
  end

  assign ptr_nxt   = (gidx == PW'(NREQ - 1)) ? '0 : gidx + PW'(1);
  assign req_g     = |(gnt_q & req);
  assign ack       = gnt_q & req & {NREQ{~full}};
  assign winc      = |ack;
  assign xfer      = winc;
  assign release_g = (state_q == GRANT) &&
                     (!req_g || (xfer && (bcnt_q == BW'(MAXBURST - 1))));
  assign pick_idle = rr_pick(req, ptr_q);
  assign pick_rel  = rr_pick(req, ptr_nxt);
  assign gnt       = gnt_q;
  assign busy      = (state_q == GRANT);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    bcnt_d  = bcnt_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = pick_idle;
          bcnt_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (xfer) begin
          bcnt_d = bcnt_q + BW'(1);
        end
        // A release re-arbitrates in the same cycle so back-to-back grants have no bubble.
        if (release_g) begin
          ptr_d  = ptr_nxt;
          gnt_d  = pick_rel;
          bcnt_d = '0;
          if (!(|pick_rel)) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or negedge w_rst) begin
    if (!w_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ptr_q   <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
      bcnt_q  <= bcnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - directed self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

  localparam int DSIZE    = 8;
  localparam int NREQ     = 4;
  localparam int MAXBURST = 4;

  logic                  wclk;
  logic                  w_rst;
  logic [NREQ-1:0]       req;
  logic [NREQ*DSIZE-1:0] req_data;
  logic                  full;
  logic [NREQ-1:0]       gnt;
  logic [NREQ-1:0]       ack;
  logic [DSIZE-1:0]      wdata;
  logic                  winc;
  logic                  busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DSIZE-1:0] dval [NREQ];

  fifo_wr_arbiter #(.DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(MAXBURST)) dut (
    .wclk     (wclk),
    .w_rst    (w_rst),
    .req      (req),
    .req_data (req_data),
    .full     (full),
    .gnt      (gnt),
    .ack      (ack),
    .wdata    (wdata),
    .winc     (winc),
    .busy     (busy)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge wclk);
    w_rst = 1'b0;
    req   = '0;
    full  = 1'b0;
    @(negedge wclk);
    w_rst = 1'b1;
  endtask

  task automatic check_xfer(input string tag, input logic [NREQ-1:0] g, input logic [DSIZE-1:0] d);
    check_eq({tag, " gnt"}, 32'(gnt), 32'(g));
    check_eq({tag, " ack"}, 32'(ack), 32'(g));
    check_eq({tag, " winc"}, 32'(winc), 32'd1);
    check_eq({tag, " wdata"}, 32'(wdata), 32'(d));
  endtask

  initial begin
    dval[0] = 8'h11;
    dval[1] = 8'h22;
    dval[2] = 8'hA5;
    dval[3] = 8'h44;
    req_data = {dval[3], dval[2], dval[1], dval[0]};

    // 1: reset holds everything quiet even with all requests up
    w_rst = 1'b0;
    req   = 4'hF;
    full  = 1'b0;
    #3;
    check_eq("rst gnt", 32'(gnt), 32'd0);
    check_eq("rst winc", 32'(winc), 32'd0);
    check_eq("rst wdata", 32'(wdata), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    @(negedge wclk);
    w_rst = 1'b1;
    req   = '0;
    @(negedge wclk);
    @(negedge wclk);
    check_eq("idle gnt", 32'(gnt), 32'd0);
    check_eq("idle busy", 32'(busy), 32'd0);

    // 2: sole requester 2, continuous writes across burst boundaries
    req = 4'b0100;
    #1;
    check_eq("t2 latency gnt", 32'(gnt), 32'd0);
    check_eq("t2 latency winc", 32'(winc), 32'd0);
    for (int k = 0; k < 2 * MAXBURST; k++) begin
      @(negedge wclk);
      check_xfer("t2", 4'b0100, 8'hA5);
    end
    check_eq("t2 busy", 32'(busy), 32'd1);

    // 3: all requesting, rotation with no gaps
    do_reset();
    req = 4'hF;
    for (int k = 0; k < NREQ * MAXBURST; k++) begin
      @(negedge wclk);
      check_xfer("t3", 4'(1 << (k / MAXBURST)), dval[k / MAXBURST]);
    end

    // 4: full stalls requester 1 mid-burst without losing its grant
    for (int k = 0; k < MAXBURST; k++) begin
      @(negedge wclk);
      check_xfer("t4 pre0", 4'b0001, dval[0]);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge wclk);
      check_xfer("t4 pre1", 4'b0010, dval[1]);
    end
    @(negedge wclk);
    full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("t4 full winc", 32'(winc), 32'd0);
      check_eq("t4 full ack", 32'(ack), 32'd0);
      check_eq("t4 full gnt", 32'(gnt), 32'b0010);
      @(negedge wclk);
    end
    full = 1'b0;
    #1;
    check_xfer("t4 post1a", 4'b0010, dval[1]);
    @(negedge wclk);
    check_xfer("t4 post1b", 4'b0010, dval[1]);
    @(negedge wclk);
    check_xfer("t4 rotate", 4'b0100, dval[2]);

    // 5: requester 1 withdraws after 2 words; requester 3 takes over after one idle cycle
    do_reset();
    req = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      @(negedge wclk);
      check_xfer("t5 burst", 4'b0010, dval[1]);
    end
    @(negedge wclk);
    req = 4'b1000;
    #1;
    check_eq("t5 gap winc", 32'(winc), 32'd0);
    check_eq("t5 gap gnt", 32'(gnt), 32'b0010);
    @(negedge wclk);
    check_xfer("t5 switch", 4'b1000, dval[3]);
    check_eq("t5 ptr", 32'(dut.ptr_q), 32'd2);

    // 6: asynchronous reset mid-burst, then pointer restarts at 0
    #2;
    w_rst = 1'b0;
    #1;
    check_eq("t6 async gnt", 32'(gnt), 32'd0);
    check_eq("t6 async winc", 32'(winc), 32'd0);
    check_eq("t6 async ack", 32'(ack), 32'd0);
    check_eq("t6 async busy", 32'(busy), 32'd0);
    req = 4'b1001;
    @(negedge wclk);
    w_rst = 1'b1;
    @(negedge wclk);
    check_xfer("t6 regrant", 4'b0001, dval[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
